// File: rtl/spi_sensor_burst_reader.sv
// spi_sensor_burst_reader: SPI mode-0 burst reader assembling NUM_CH little-endian samples per transaction
module spi_sensor_burst_reader #(
  parameter int          CLK_DIV      = 4,
  parameter int          NUM_CH       = 3,
  parameter int          BYTES_PER_CH = 2,
  parameter int          SAMPLE_W     = 12,
  parameter logic [7:0]  READ_CMD     = 8'h0B,
  parameter logic [7:0]  START_ADDR   = 8'h0E,
  parameter int          PERIOD       = 5000
) (
  input  logic                       clk_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       auto_en,
  input  logic                       MISO,
  output logic                       SCLK,
  output logic                       MOSI,
  output logic                       n_CS,
  output logic [NUM_CH*SAMPLE_W-1:0] ch_data,
  output logic                       data_valid,
  output logic                       busy,
  output logic [15:0]                frame_count,
  output logic [2:0]                 spi_state
);
  localparam int TOTAL_BITS = 8*(2+NUM_CH*BYTES_PER_CH);
  localparam int DATA_BITS  = 8*NUM_CH*BYTES_PER_CH;
  localparam int DW = $clog2(2*CLK_DIV);
  localparam int BW = $clog2(TOTAL_BITS);
  localparam int TW = $clog2(PERIOD+1);
  localparam logic [15:0] HDR = {READ_CMD, START_ADDR};

  typedef enum logic [2:0] {IDLE = 3'd0, SETUP = 3'd1, SHIFT = 3'd2, HOLD = 3'd3, GAP = 3'd4, DONE = 3'd5} state_t;
  state_t state, state_nxt;

  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [TW-1:0]        timer;
  logic [15:0]          tx_sr;
  logic [DATA_BITS-1:0] rx;
  logic [NUM_CH*SAMPLE_W-1:0] next_data;
  logic half_end, bit_end, last_bit, trigger;

  assign half_end = div_cnt == DW'(CLK_DIV-1);
  assign bit_end  = div_cnt == DW'(2*CLK_DIV-1);
  assign last_bit = bit_cnt == BW'(TOTAL_BITS-1);
  assign trigger  = start || (auto_en && timer == TW'(PERIOD-1));

  assign n_CS      = !(state == SETUP || state == SHIFT || state == HOLD);
  assign SCLK      = state == SHIFT && div_cnt >= DW'(CLK_DIV);
  assign MOSI      = (state == SETUP || state == SHIFT) && tx_sr[15];
  assign busy      = state != IDLE;
  assign spi_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = trigger ? SETUP : IDLE;
      SETUP:   state_nxt = half_end ? SHIFT : SETUP;
      SHIFT:   state_nxt = bit_end && last_bit ? HOLD : SHIFT;
      HOLD:    state_nxt = half_end ? GAP : HOLD;
      GAP:     state_nxt = half_end ? DONE : GAP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;

  // rx is the shadow buffer: the first data byte ends up in its top byte
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar b = 0; b < SAMPLE_W; b++) begin : g_bit
      assign next_data[c*SAMPLE_W+b] = rx[DATA_BITS-8-8*(c*BYTES_PER_CH+b/8)+b%8];
    end
  end

  always_ff @(posedge clk_50 or negedge reset)
    if (!reset) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      tx_sr       <= '0;
      rx          <= '0;
      ch_data     <= '0;
      data_valid  <= 1'b0;
      frame_count <= '0;
    end else begin
      div_cnt     <= (state == IDLE || state == DONE || (state == SHIFT ? bit_end : half_end)) ? '0 : div_cnt + 1'b1;
      bit_cnt     <= state != SHIFT ? '0 : bit_end ? bit_cnt + 1'b1 : bit_cnt;
      timer       <= (state == IDLE && auto_en && !trigger) ? timer + 1'b1 : '0;
      tx_sr       <= state == IDLE ? HDR : (state == SHIFT && bit_end) ? {tx_sr[14:0], 1'b0} : tx_sr;
      rx          <= (state == SHIFT && half_end) ? {rx[DATA_BITS-2:0], MISO} : rx;
      ch_data     <= state == DONE ? next_data : ch_data;
      data_valid  <= state == DONE;
      frame_count <= state == DONE ? frame_count + 1'b1 : frame_count;
    end
endmodule

// File: tb/tb_spi_sensor_burst_reader.sv
// tb_spi_sensor_burst_reader: directed tests with a mode-0 sensor model for default and reduced configurations
module tb_spi_sensor_burst_reader;
  logic clk_50 = 1'b0, reset = 1'b1, start = 1'b0, auto_en = 1'b0, miso;
  logic sclk, mosi, n_cs, data_valid, busy;
  logic [35:0] ch_data;
  logic [15:0] frame_count;
  logic [2:0]  spi_state;
  logic start2 = 1'b0, miso2;
  logic sclk2, mosi2, n_cs2, dv2, busy2;
  logic [7:0]  ch2;
  logic [15:0] fc2;
  logic [2:0]  st2;
  int checks = 0, failures = 0;

  always #5 clk_50 = ~clk_50;

  spi_sensor_burst_reader dut (
    .clk_50(clk_50), .reset(reset), .start(start), .auto_en(auto_en), .MISO(miso),
    .SCLK(sclk), .MOSI(mosi), .n_CS(n_cs), .ch_data(ch_data), .data_valid(data_valid),
    .busy(busy), .frame_count(frame_count), .spi_state(spi_state));

  spi_sensor_burst_reader #(.NUM_CH(1), .BYTES_PER_CH(1), .SAMPLE_W(8), .CLK_DIV(2)) dut2 (
    .clk_50(clk_50), .reset(reset), .start(start2), .auto_en(1'b0), .MISO(miso2),
    .SCLK(sclk2), .MOSI(mosi2), .n_CS(n_cs2), .ch_data(ch2), .data_valid(dv2),
    .busy(busy2), .frame_count(fc2), .spi_state(st2));

  // sensor model: MISO changes on SCLK falling edges, bit index restarts at n_CS fall
  logic [63:0] frame = '0, mosi_cap = '0;
  int rises = 0, falls = 0, cs_base = 0, idx;
  always @(posedge sclk) begin
    rises <= rises + 1;
    mosi_cap <= {mosi_cap[62:0], mosi};
  end
  always @(negedge sclk) falls <= falls + 1;
  always @(negedge n_cs) cs_base <= falls;
  always_comb begin
    idx = falls - cs_base;
    miso = (idx >= 0 && idx < 64) ? frame[63-idx] : 1'b0;
  end

  logic [23:0] frame2 = '0, mosi_cap2 = '0;
  int falls2 = 0, cs_base2 = 0, idx2;
  always @(posedge sclk2) mosi_cap2 <= {mosi_cap2[22:0], mosi2};
  always @(negedge sclk2) falls2 <= falls2 + 1;
  always @(negedge n_cs2) cs_base2 <= falls2;
  always_comb begin
    idx2 = falls2 - cs_base2;
    miso2 = (idx2 >= 0 && idx2 < 24) ? frame2[23-idx2] : 1'b0;
  end

  task automatic pulse_start;
    @(posedge clk_50); #1 start = 1'b1;
    @(posedge clk_50); #1 start = 1'b0;
  endtask

  task automatic wait_dv(input int bound, output int lat);
    lat = -1;
    for (int n = 1; n <= bound; n++) begin
      @(posedge clk_50); #1;
      if (data_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    repeat (4) @(posedge clk_50);
    #1 reset = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk_50); #1;
      checks++;
      if ({n_cs, sclk, busy, data_valid, spi_state} !== 7'b1000000 || ch_data !== '0 || frame_count !== '0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: ncs=%b sclk=%b busy=%b dv=%b st=%0d ch=%h fc=%0d, want 1 0 0 0 0 0 0",
                 n, n_cs, sclk, busy, data_valid, spi_state, ch_data, frame_count);
      end
    end
  endtask

  task automatic test_basic;
    int lat, r0;
    frame = 64'h0000_3412_CDAB_FF07;
    r0 = rises;
    pulse_start;
    wait_dv(2000, lat);
    checks++; if (lat !== 525) begin failures++; $display("FAIL basic_latency got %0d want 525", lat); end
    checks++; if (ch_data !== 36'h7FFBCD234) begin failures++; $display("FAIL basic_data got %h want 7ffbcd234", ch_data); end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL basic_fcount got %0d want 1", frame_count); end
    checks++; if (rises - r0 !== 64) begin failures++; $display("FAIL basic_sclk_edges got %0d want 64", rises - r0); end
    checks++; if (mosi_cap !== {16'h0B0E, 48'h0}) begin failures++; $display("FAIL basic_mosi got %h want 0b0e000000000000", mosi_cap); end
    @(posedge clk_50); #1;
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL basic_dv_pulse got %b want 0", data_valid); end
    checks++; if (ch_data !== 36'h7FFBCD234 || n_cs !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_hold ch=%h ncs=%b busy=%b want 7ffbcd234 1 0", ch_data, n_cs, busy);
    end
  endtask

  task automatic test_ones_zeros;
    int lat;
    bit held;
    frame = 64'h0000_FFFF_FFFF_FFFF;
    pulse_start;
    wait_dv(2000, lat);
    checks++; if (ch_data !== 36'hFFFFFFFFF) begin failures++; $display("FAIL ones_data got %h want fffffffff", ch_data); end
    frame = '0;
    pulse_start;
    held = 1'b1;
    lat = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk_50); #1;
      if (data_valid) begin
        lat = n;
        break;
      end
      if (ch_data !== 36'hFFFFFFFFF) held = 1'b0;
    end
    checks++; if (!held) begin failures++; $display("FAIL zeros_held got early change want fffffffff until valid"); end
    checks++; if (lat !== 525) begin failures++; $display("FAIL zeros_latency got %0d want 525", lat); end
    checks++; if (ch_data !== '0) begin failures++; $display("FAIL zeros_data got %h want 0", ch_data); end
    checks++; if (frame_count !== 16'd3) begin failures++; $display("FAIL zeros_fcount got %0d want 3", frame_count); end
  endtask

  task automatic test_auto;
    int lat;
    bit quiet;
    frame = 64'h0000_A1B2_C3D4_E5F6;
    @(posedge clk_50); #1 auto_en = 1'b1;
    wait_dv(6000, lat);
    checks++; if (lat !== 5525) begin failures++; $display("FAIL auto_first got %0d want 5525", lat); end
    wait_dv(7000, lat);
    checks++; if (lat !== 5525) begin failures++; $display("FAIL auto_spacing got %0d want 5525", lat); end
    checks++; if (ch_data !== 36'h6E54C32A1) begin failures++; $display("FAIL auto_data got %h want 6e54c32a1", ch_data); end
    repeat (5100) @(posedge clk_50);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL auto_midburst_busy got %b want 1", busy); end
    auto_en = 1'b0;
    wait_dv(600, lat);
    checks++; if (lat !== 425) begin failures++; $display("FAIL auto_finish got %0d want 425", lat); end
    checks++; if (frame_count !== 16'd6) begin failures++; $display("FAIL auto_fcount got %0d want 6", frame_count); end
    quiet = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      @(posedge clk_50); #1;
      if (data_valid || busy) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL auto_stop got burst want none"); end
  endtask

  task automatic test_reset_mid;
    int lat, r0;
    bit reached;
    frame = 64'h0000_1122_3344_5566;
    r0 = rises;
    pulse_start;
    reached = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk_50); #1;
      if (rises - r0 >= 30) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (!reached) begin failures++; $display("FAIL abort_reach got %0d edges want 30", rises - r0); end
    reset = 1'b0;
    #1;
    checks++; if (n_cs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_pins ncs=%b sclk=%b busy=%b want 1 0 0", n_cs, sclk, busy);
    end
    checks++; if (ch_data !== '0 || frame_count !== '0) begin
      failures++; $display("FAIL abort_clear ch=%h fc=%0d want 0 0", ch_data, frame_count);
    end
    repeat (3) @(posedge clk_50);
    #1 reset = 1'b1;
    r0 = rises;
    pulse_start;
    wait_dv(2000, lat);
    checks++; if (lat !== 525) begin failures++; $display("FAIL abort_next_latency got %0d want 525", lat); end
    checks++; if (ch_data !== 36'h655433211) begin failures++; $display("FAIL abort_next_data got %h want 655433211", ch_data); end
    checks++; if (frame_count !== 16'd1 || rises - r0 !== 64) begin
      failures++; $display("FAIL abort_next_count fc=%0d edges=%0d want 1 64", frame_count, rises - r0);
    end
  endtask

  task automatic test_small;
    int lat;
    frame2 = 24'h0000A5;
    @(posedge clk_50); #1 start2 = 1'b1;
    @(posedge clk_50); #1 start2 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk_50); #1;
      if (dv2) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 103) begin failures++; $display("FAIL small_latency got %0d want 103", lat); end
    checks++; if (ch2 !== 8'hA5) begin failures++; $display("FAIL small_data got %h want a5", ch2); end
    checks++; if (fc2 !== 16'd1) begin failures++; $display("FAIL small_fcount got %0d want 1", fc2); end
    checks++; if (mosi_cap2 !== 24'h0B0E00) begin failures++; $display("FAIL small_mosi got %h want 0b0e00", mosi_cap2); end
    @(posedge clk_50); #1;
    checks++; if (dv2 !== 1'b0 || busy2 !== 1'b0 || st2 !== 3'd0 || n_cs2 !== 1'b1) begin
      failures++; $display("FAIL small_idle dv=%b busy=%b st=%0d ncs=%b want 0 0 0 1", dv2, busy2, st2, n_cs2);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ones_zeros;
    test_auto;
    test_reset_mid;
    test_small;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
